// File: rtl/stream_max_pkg.sv
// Shared types and constants for the frame maximum tracker.
package stream_max_pkg;

    localparam int DATA_W            = 4;
    localparam int DEFAULT_FRAME_LEN = 8;
    localparam int DEFAULT_CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/four_bit_comparator.sv
// Unsigned magnitude comparator: reports x > y and x == y.
module four_bit_comparator
    import stream_max_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic              o_gt,
    output logic              o_eq
);

    assign o_gt = (x > y);
    assign o_eq = (x == y);

endmodule

// File: rtl/stream_max_finder.sv
// Frame-based running maximum with first-index and tie count; result on a valid/ready port.
// Define STREAM_MAX_FINDER_MIN_TRACK_EN to also track the frame minimum and its first index.
module stream_max_finder
    import stream_max_pkg::*;
#(
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int CNT_W     = DEFAULT_CNT_W
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] max_val,
    output logic [CNT_W-1:0]  max_idx,
    output logic [CNT_W-1:0]  tie_cnt,
    output logic              busy
`ifdef STREAM_MAX_FINDER_MIN_TRACK_EN
    ,
    output logic [DATA_W-1:0] min_val,
    output logic [CNT_W-1:0]  min_idx
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic               busy_reg;
    logic [DATA_W-1:0]  max_val_reg;
    logic [CNT_W-1:0]   max_idx_reg;
    logic [CNT_W-1:0]   tie_cnt_reg;

    logic               max_gt;
    logic               max_eq;
    logic               accept;

    assign accept = in_valid & in_ready_reg;

    four_bit_comparator u_max_cmp (
        .x    (in_data),
        .y    (max_val_reg),
        .o_gt (max_gt),
        .o_eq (max_eq)
    );

`ifdef STREAM_MAX_FINDER_MIN_TRACK_EN
    logic [DATA_W-1:0]  min_val_reg;
    logic [CNT_W-1:0]   min_idx_reg;
    logic               min_gt;
    logic               min_eq_unused;

    // Strictly-greater only, so an equal later sample never moves min_idx.
    four_bit_comparator u_min_cmp (
        .x    (min_val_reg),
        .y    (in_data),
        .o_gt (min_gt),
        .o_eq (min_eq_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_val_reg <= '0;
            min_idx_reg <= '0;
        end else if (state_reg == ACCUM && accept) begin
            if (cnt_reg == '0) begin
                min_val_reg <= in_data;
                min_idx_reg <= '0;
            end else if (min_gt) begin
                min_val_reg <= in_data;
                min_idx_reg <= cnt_reg;
            end
        end
    end

    assign min_val = min_val_reg;
    assign min_idx = min_idx_reg;
`endif

    // Control and result registers; results stay put after handoff until the next sample 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            max_val_reg   <= '0;
            max_idx_reg   <= '0;
            tie_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= ACCUM;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end

                ACCUM: begin
                    if (accept) begin
                        if (cnt_reg == '0) begin
                            max_val_reg <= in_data;
                            max_idx_reg <= '0;
                            tie_cnt_reg <= ONE;
                        end else if (max_gt) begin
                            max_val_reg <= in_data;
                            max_idx_reg <= cnt_reg;
                            tie_cnt_reg <= ONE;
                        end else if (max_eq) begin
                            tie_cnt_reg <= tie_cnt_reg + ONE;
                        end

                        cnt_reg <= cnt_reg + ONE;

                        if (cnt_reg == LAST_IDX) begin
                            state_reg     <= DONE;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign max_val   = max_val_reg;
    assign max_idx   = max_idx_reg;
    assign tie_cnt   = tie_cnt_reg;

endmodule

// File: tb/tb_stream_max_finder.sv
// Scoreboard bench for stream_max_finder with a 4-sample frame.
module tb_stream_max_finder;

    localparam int FL = 4;
    localparam int CW = 4;

    typedef logic [3:0] frame_t [FL];

    typedef struct {
        int max_val;
        int max_idx;
        int tie_cnt;
        int min_val;
        int min_idx;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    max_val;
    logic [CW-1:0] max_idx;
    logic [CW-1:0] tie_cnt;
    logic          busy;
`ifdef STREAM_MAX_FINDER_MIN_TRACK_EN
    logic [3:0]    min_val;
    logic [CW-1:0] min_idx;
`endif

    int vectors;
    int miscompares;
    exp_t sb[$];

    stream_max_finder #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .max_val   (max_val),
        .max_idx   (max_idx),
        .tie_cnt   (tie_cnt),
        .busy      (busy)
`ifdef STREAM_MAX_FINDER_MIN_TRACK_EN
        ,
        .min_val   (min_val),
        .min_idx   (min_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end else begin
            $display("ok   %s: %0d", tag, observed);
        end
    endtask

    function automatic exp_t model(input frame_t s);
        exp_t e;
        int mx;
        int mn;
        mx = 0;
        mn = 15;
        for (int i = 0; i < FL; i++) begin
            if (int'(s[i]) > mx) mx = int'(s[i]);
            if (int'(s[i]) < mn) mn = int'(s[i]);
        end
        e.max_val = mx;
        e.min_val = mn;
        e.max_idx = -1;
        e.min_idx = -1;
        e.tie_cnt = 0;
        for (int i = 0; i < FL; i++) begin
            if (int'(s[i]) == mx) begin
                e.tie_cnt++;
                if (e.max_idx < 0) e.max_idx = i;
            end
            if (int'(s[i]) == mn && e.min_idx < 0) e.min_idx = i;
        end
        return e;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ".in_ready"},  int'(in_ready),  0);
        check({tag, ".out_valid"}, int'(out_valid), 0);
        check({tag, ".busy"},      int'(busy),      0);
        check({tag, ".max_val"},   int'(max_val),   0);
        check({tag, ".max_idx"},   int'(max_idx),   0);
        check({tag, ".tie_cnt"},   int'(tie_cnt),   0);
`ifdef STREAM_MAX_FINDER_MIN_TRACK_EN
        check({tag, ".min_val"},   int'(min_val),   0);
        check({tag, ".min_idx"},   int'(min_idx),   0);
`endif
    endtask

    task automatic check_result(input string tag, input exp_t e);
        check({tag, ".max_val"}, int'(max_val), e.max_val);
        check({tag, ".max_idx"}, int'(max_idx), e.max_idx);
        check({tag, ".tie_cnt"}, int'(tie_cnt), e.tie_cnt);
`ifdef STREAM_MAX_FINDER_MIN_TRACK_EN
        check({tag, ".min_val"}, int'(min_val), e.min_val);
        check({tag, ".min_idx"}, int'(min_idx), e.min_idx);
`endif
    endtask

    // Starts a frame, streams samples (optionally with a bubble before each) and ends at the
    // first negedge after the last accept; pushes the expected result.
    task automatic run_frame(input string tag, input frame_t s, input bit bubbles);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".start_in_ready"}, int'(in_ready), 1);
        sb.push_back(model(s));
        for (int i = 0; i < FL; i++) begin
            if (bubbles) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = s[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 4'd0;
        check({tag, ".out_valid_rise"}, int'(out_valid), 1);
        check({tag, ".in_ready_done"},  int'(in_ready),  0);
    endtask

    // Holds out_ready low for 'hold' cycles (optionally poking start/in_valid),
    // then hands off, optionally with a simultaneous start that must be ignored.
    task automatic collect(input string tag, input int hold, input bit poke);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 1, 0);
            return;
        end
        check({tag, ".out_valid"}, int'(out_valid), 1);
        e = sb.pop_front();
        check_result(tag, e);
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            start     = poke;
            in_valid  = poke;
            in_data   = 4'd15;
            @(negedge clk);
            check({tag, ".hold_valid"}, int'(out_valid), 1);
            check({tag, ".hold_max"},   int'(max_val),   e.max_val);
            check({tag, ".hold_tie"},   int'(tie_cnt),   e.tie_cnt);
        end
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b1;
        start     = poke;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        check({tag, ".idle_valid"}, int'(out_valid), 0);
        check({tag, ".idle_ready"}, int'(in_ready),  0);
        check({tag, ".idle_busy"},  int'(busy),      0);
        check_result({tag, ".kept"}, e);
        if (poke) begin
            @(negedge clk);
            check({tag, ".start_ignored"}, int'(in_ready), 0);
        end
    endtask

    initial begin
        frame_t f;
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("reset");

        f = '{4'd3, 4'd9, 4'd2, 4'd7};
        run_frame("basic", f, 1'b0);
        collect("basic", 5, 1'b1);

        out_ready = 1'b1;
        f = '{4'd5, 4'd12, 4'd12, 4'd4};
        run_frame("tie", f, 1'b1);
        collect("tie", 0, 1'b0);

        f = '{4'd0, 4'd0, 4'd0, 4'd0};
        run_frame("all_eq", f, 1'b0);
        collect("all_eq", 1, 1'b0);

        f = '{4'd1, 4'd2, 4'd3, 4'd15};
        run_frame("last_max", f, 1'b0);
        collect("last_max", 0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < FL; i++) f[i] = 4'($urandom_range(0, 15));
            run_frame($sformatf("rand%0d", r), f, r[0]);
            collect($sformatf("rand%0d", r), r, 1'b0);
        end

        // Abort a frame after two accepts.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'd15;
        @(negedge clk);
        in_data  = 4'd1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_abort");

        f = '{4'd4, 4'd4, 4'd8, 4'd1};
        run_frame("after_abort", f, 1'b0);
        collect("after_abort", 0, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
